// File: rtl/led_share_sched.sv
// Round-robin time-slicing of the status LEDs between NUM_REQ requesters,
// with PWM dimming of the granted pattern.
module led_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int LED_W   = 3,
  parameter int PWM_W   = 4,
  parameter int HOLD_W  = 22
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LED_W-1:0]     pattern,
  input  logic [NUM_REQ*PWM_W-1:0]     level,
  input  logic [HOLD_W-1:0]            hold_cycles,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         done,
  output logic [$clog2(NUM_REQ)-1:0]   done_id,
  output logic                         busy,
  output logic [LED_W-1:0]             leds
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    pick;
  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_oh;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   lvl_l;
  logic [LED_W-1:0]   pat_l;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [LED_W-1:0]   pat_a [NUM_REQ];
  logic [PWM_W-1:0]   lvl_a [NUM_REQ];

  // All-ones level is forced fully on rather than 15/16 duty.
  function automatic logic pwm_on(input logic [PWM_W-1:0] lvl, input logic [PWM_W-1:0] cnt);
    return (&lvl) || (cnt < lvl);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pat_a[i] = pattern[i*LED_W +: LED_W];
      lvl_a[i] = level[i*PWM_W +: PWM_W];
    end
  end

  // Circular first-set scan starting at ptr.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    idx      = 0;
    idx_w    = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (!pick_vld && req[idx_w]) begin
        pick     = idx_w;
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_oh = NUM_REQ'(1) << pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      busy     <= 1'b0;
      leds     <= '0;
      ptr      <= '0;
      pwm_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          grant <= '0;
          busy  <= 1'b0;
          leds  <= '0;
          if (pick_vld) begin
            state    <= SHOW;
            grant    <= pick_oh;
            busy     <= 1'b1;
            winner   <= pick;
            pat_l    <= pat_a[pick];
            lvl_l    <= lvl_a[pick];
            hold_cnt <= (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;
            leds     <= pwm_on(lvl_a[pick], pwm_cnt) ? pat_a[pick] : '0;
          end
        end
        SHOW: begin
          if (hold_cnt == '0) begin
            state   <= GAP;
            grant   <= '0;
            leds    <= '0;
            done    <= 1'b1;
            done_id <= winner;
            ptr     <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
            leds     <= pwm_on(lvl_l, pwm_cnt) ? pat_l : '0;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_share_sched.md
Name: led_share_sched

Overview:
- Time-slicing scheduler that shares the board's status LEDs between several requesters on the iCE40 LP1K.
- Examples of requesters: counter taps, oscillator-health monitors, debug FSMs.
- Each requester presents an LED pattern and a brightness level. The block grants the LEDs round-robin for a programmable hold time and PWM-dims the granted pattern.
- It sits between the clock-domain logic (ring-oscillator-clocked counters, etc.) and the led1..led3 pins in top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LED_W, 3, number of LEDs driven
- PWM_W, 4, brightness resolution in bits
- HOLD_W, 22, width of hold-time operand/counter

Ports:
- clk  in  1  single system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- pattern  in  NUM_REQ*LED_W  requester i pattern at bits [i*LED_W +: LED_W]
- level  in  NUM_REQ*PWM_W  requester i brightness at bits [i*PWM_W +: PWM_W]
- hold_cycles  in  HOLD_W  slot length in clk cycles; 0 treated as 1
- grant  out  NUM_REQ  one-hot current owner; all-zero when none
- done  out  1  one-cycle pulse when a slot ends
- done_id  out  $clog2(NUM_REQ)  index of the requester whose slot ended; valid with done
- busy  out  1  high in SHOW and GAP
- leds  out  LED_W  LED drive, active-high

Behaviour:
- Reset (synchronous, rst=1 at posedge) sets: state IDLE, grant=0, done=0, done_id=0, busy=0, leds=0, rr pointer=0, pwm counter=0, hold counter=0. rst mid-slot aborts the slot immediately with no done pulse.
- FSM states are IDLE, SHOW, GAP.
- IDLE:
  - If req≠0, pick the first set bit scanning circularly from index ptr upward, with wrap-around.
  - Next cycle: state=SHOW, grant=onehot(winner), busy=1.
  - Latch winner's pattern and level, and latch hold = max(hold_cycles,1).
  - If req==0, stay in IDLE with all outputs 0.
- SHOW:
  - Lasts exactly the latched hold cycles, measured from the first SHOW cycle.
  - On the last cycle, next state=GAP.
  - Changes to req, pattern, level or hold_cycles during SHOW have no effect; latched values are used.
  - Deasserting req does not abort the slot.
- GAP:
  - Exactly 1 cycle: grant=0, leds=0, busy=1, done=1, done_id=winner.
  - ptr = (winner+1) mod NUM_REQ.
  - Next state=IDLE.
- Slot cost is 1 IDLE + hold SHOW + 1 GAP cycles. A continuously requesting sole requester gets a slot every hold+2 cycles.
- PWM:
  - Free-running PWM_W-bit counter pwm_cnt; increments every clk and wraps at 2^PWM_W-1 → 0. Runs in all states.
  - In SHOW, leds[k] = pat_latched[k] & (lvl_latched == all-ones ? 1 : pwm_cnt < lvl_latched).
  - level=0 gives LEDs off for the whole slot. All-ones gives constant on. Otherwise duty = level/2^PWM_W.
  - leds is registered: 1-cycle latency from pwm_cnt to pin.
- Fairness: with all req high, grants rotate 0,1,2,...,NUM_REQ-1,0,...
- A requester that reasserts req the cycle after its own done is served only after any other pending requester.
- Hold counter is HOLD_W wide; the maximum slot is 2^HOLD_W-1 cycles, with no overflow.
- Invariants (assertable):
  - grant is one-hot or zero.
  - grant≠0 only in SHOW.
  - done is never high in two consecutive cycles.

Test Plan:
- Reset/idle: assert rst 3 cycles mid-SHOW with req=4'b0001 → the next cycle grant=0, leds=0, busy=0, no done; after rst release, slot restarts in IDLE with grant=4'b0001.
- Single requester: req=4'b0100, hold_cycles=5, pattern2=3'b101, level2=4'hF → grant=4'b0100 for exactly 5 cycles, leds=3'b101 constant; then 1 GAP cycle with done=1, done_id=2; next grant 7 cycles after the previous grant start.
- Round-robin: req=4'b1111, hold_cycles=2 → grant sequence 0001,0010,0100,1000,0001, each separated by a GAP with done_id 0,1,2,3.
- PWM duty: level=4'h4, pattern=3'b111, hold_cycles=64 → each LED high in exactly 16 of 64 SHOW cycles. Repeat with level=0 → 0 high; level=4'hF → 64 high.
- Latching and edge cases:
  - Change pattern/level/hold_cycles and drop req during SHOW → outputs unchanged; slot length stays as originally latched.
  - hold_cycles=0 → a 1-cycle SHOW.
- Priority rotation: req=4'b1001 with ptr=0 → grant 0001 first, then 1000, then 0001.
